alu_share_ctrl: RTL and testbench

Two-requester arbiter and sequencer for the shared 8-bit ALU (add, subtract, two's-complement negate, OR, XOR, 9-bit result). Each requester presents an operand pair and an opcode with a valid/ready handshake. The block picks one requester round-robin, registers its operands and drives the ALU from those registers. It registers the 9-bit result and returns it on a single response channel tagged with the requester ID.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu8.sv | 27 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/alu_share_ctrl.sv | 135 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared-ALU slice.
//   - ALU opcode constants
//   - FSM state encoding for alu_share_ctrl
//   - op_is_illegal(): true for opcodes that have no ALU operation
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_NEG = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_illegal(input logic [2:0] op);
        return !(op inside {OP_ADD, OP_SUB, OP_NEG, OP_OR, OP_XOR});
    endfunction

endpackage

// File: rtl/alu8.sv
// alu8: combinational 8-bit ALU with 9-bit result (bit 8 = carry).
// Ports:
//   a, b  in  8 : operands
//   op    in  3 : opcode (see alu_pkg)
//   y     out 9 : result; unused opcodes give 0
import alu_pkg::*;

module alu8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [2:0] op,
    output logic [8:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:  y = {1'b0, a} + {1'b0, b};
            OP_SUB:  y = {1'b0, a - b};
            OP_NEG:  y = {1'b0, ~a + 8'd1};
            OP_OR:   y = {1'b0, a | b};
            OP_XOR:  y = {1'b0, a ^ b};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin grant (combinational).
// Ports:
//   valid      in  2 : request valids
//   last_grant in  1 : requester served most recently
//   grant      out 2 : one-hot grant, or 0 when nothing is valid
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            // Tie: the requester not served last time wins.
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-requester arbiter/sequencer for a shared 8-bit ALU.
// IDLE grants one requester (round-robin) and captures its operands,
// EXEC registers the ALU result, RESP holds it until the consumer takes it.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   reqN_valid/ready/a/b/op (N = 0, 1) : requester channels
//   rsp_valid/ready/id/data/err        : response channel
//   busy                               : FSM not in IDLE
// Parameter PRIO_INIT: requester that wins the first tie after reset.
// Build macro ALU_SHARE_OPCHK_EN: flag illegal opcodes on rsp_err.
import alu_pkg::*;

module alu_share_ctrl #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [7:0] req0_a,
    input  logic [7:0] req0_b,
    input  logic [2:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [7:0] req1_a,
    input  logic [7:0] req1_b,
    input  logic [2:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [8:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    // last_grant starts as the opposite of the preferred requester
    localparam logic LAST_GRANT_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

    state_e     state_q;
    logic [7:0] a_q, b_q;
    logic [2:0] op_q;
    logic       id_q;
    logic [8:0] rsp_data_q;
    logic       rsp_valid_q;
    logic       busy_q;
    logic       last_grant_q;
    logic [1:0] grant;
    logic [8:0] alu_y;

    rr_arb2 u_arb (
        .valid      ({req1_valid, req0_valid}),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // ALU sees only the captured operands, never the live request fields
    alu8 u_alu (
        .a  (a_q),
        .b  (b_q),
        .op (op_q),
        .y  (alu_y)
    );

    assign req0_ready = (state_q == ST_IDLE) && grant[0];
    assign req1_ready = (state_q == ST_IDLE) && grant[1];

`ifdef ALU_SHARE_OPCHK_EN
    logic rsp_err_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= LAST_GRANT_INIT;
`ifdef ALU_SHARE_OPCHK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|grant) begin
                        a_q     <= grant[1] ? req1_a  : req0_a;
                        b_q     <= grant[1] ? req1_b  : req0_b;
                        op_q    <= grant[1] ? req1_op : req0_op;
                        id_q    <= grant[1];
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
`ifdef ALU_SHARE_OPCHK_EN
                    rsp_err_q  <= op_is_illegal(op_q);
                    rsp_data_q <= op_is_illegal(op_q) ? '0 : alu_y;
`else
                    rsp_data_q <= alu_y;
`endif
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        last_grant_q <= id_q;
                        rsp_valid_q  <= 1'b0;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

`ifdef ALU_SHARE_OPCHK_EN
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed-vector bench for alu_share_ctrl (PRIO_INIT = 0).
// Inputs are driven and outputs sampled around the falling clock edge.
module tb_alu_share_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_ready;
    logic [7:0] req0_a, req0_b;
    logic [2:0] req0_op;
    logic       req1_valid, req1_ready;
    logic [7:0] req1_a, req1_b;
    logic [2:0] req1_op;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [8:0] rsp_data;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    localparam logic EXP_ILL_ERR =
`ifdef ALU_SHARE_OPCHK_EN
        1'b1;
`else
        1'b0;
`endif

    always #5 clk = ~clk;

    alu_share_ctrl #(.PRIO_INIT(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction from requester `id`. `hold` = cycles of rsp_ready low in RESP.
    task automatic do_op(input logic id, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic [8:0] exp_data,
                         input logic exp_err, input int unsigned hold);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
        #1;
        chk("idle_ready0", req0_ready, !id);
        chk("idle_ready1", req1_ready, id);
        @(negedge clk);                     // EXEC
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("exec_rsp_valid", rsp_valid, 0);
        chk("exec_busy", busy, 1);
        @(negedge clk);                     // RESP
        chk("resp_valid", rsp_valid, 1);
        chk("resp_data", rsp_data, exp_data);
        chk("resp_id", rsp_id, id);
        chk("resp_err", rsp_err, exp_err);
        if (hold > 0) begin
            req0_valid = 1'b1; req1_valid = 1'b1;
            for (int unsigned i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("bp_valid", rsp_valid, 1);
                chk("bp_data", rsp_data, exp_data);
                chk("bp_id", rsp_id, id);
                chk("bp_busy", busy, 1);
                chk("bp_ready0", req0_ready, 0);
                chk("bp_ready1", req1_ready, 0);
            end
            req0_valid = 1'b0; req1_valid = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);                     // back in IDLE
        rsp_ready = 1'b0;
        chk("post_busy", busy, 0);
        chk("post_valid", rsp_valid, 0);
    endtask

    initial begin
        logic [8:0] cont_data [2];
        cont_data[0] = 9'h007;              // 3 + 4
        cont_data[1] = 9'h0FF;              // AA ^ 55

        rst_n = 1'b0; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);

        // Contention: both valid from reset, consumer always ready
        req0_valid = 1'b1; req0_a = 8'd3;  req0_b = 8'd4;  req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_op = 3'b110;
        rsp_ready  = 1'b1;
        rst_n      = 1'b1;
        for (int unsigned k = 0; k < 4; k++) begin
            #1;
            chk("cont_ready0", req0_ready, (k % 2) == 0);
            chk("cont_ready1", req1_ready, (k % 2) == 1);
            @(negedge clk);                 // EXEC
            chk("cont_busy", busy, 1);
            @(negedge clk);                 // RESP
            chk("cont_valid", rsp_valid, 1);
            chk("cont_id", rsp_id, k % 2);
            chk("cont_data", rsp_data, cont_data[k % 2]);
            @(negedge clk);                 // IDLE
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;

        do_op(1'b0, 8'hC8, 8'h64, 3'b001, 9'h12C, 1'b0, 0);  // add with carry
        do_op(1'b1, 8'd5,  8'd10, 3'b010, 9'h0FB, 1'b0, 0);  // sub wraps
        do_op(1'b1, 8'd1,  8'd0,  3'b011, 9'h0FF, 1'b0, 0);  // negate
        do_op(1'b0, 8'hFF, 8'h01, 3'b111, 9'h000, EXP_ILL_ERR, 0);
        do_op(1'b0, 8'h80, 8'h80, 3'b001, 9'h100, 1'b0, 5);  // backpressure

        // Reset while in RESP
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 8'hAA; req1_b = 8'h55; req1_op = 3'b110;
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("prerst_valid", rsp_valid, 1);
        chk("prerst_id", rsp_id, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", rsp_valid, 0);
        chk("midrst_data", rsp_data, 0);
        chk("midrst_id", rsp_id, 0);
        chk("midrst_busy", busy, 0);
        #1;
        rst_n = 1'b1;
        do_op(1'b1, 8'hF0, 8'h0F, 3'b101, 9'h0FF, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
